// File: rtl/base_address_wr_if.sv
// base_address_wr_if: BRAM port and post handshake bundle of the mailbox writer
interface base_address_wr_if #(
    parameter int SW = 4
);
    logic          ram_clk;
    logic          ram_rst;
    logic [31:0]   ram_addr;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [31:0]   ram_wd_data;
    logic [31:0]   ram_rd_data;
    logic          post_valid;
    logic          post_ready;
    logic [31:0]   post_data;
    logic          Post_Done;
    logic          ack_timeout;
    logic [SW-1:0] slot_idx;

    modport master (
        output ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data,
        output post_ready, Post_Done, ack_timeout, slot_idx,
        input  ram_rd_data, post_valid, post_data
    );

    modport slave (
        input  ram_clk, ram_rst, ram_addr, ram_en, ram_we, ram_wd_data,
        input  post_ready, Post_Done, ack_timeout, slot_idx,
        output ram_rd_data, post_valid, post_data
    );
endinterface

// File: rtl/base_address_wr.sv
// base_address_wr: posts base addresses into a BRAM mailbox ring and polls each slot's tag for the PS ack
module base_address_wr #(
    parameter logic [31:0] START_ADDR  = 32'h4580_0000,
    parameter int unsigned NUM_SLOTS   = 16,
    parameter logic [31:0] TAG_INIT    = 32'h0001_0030,
    parameter logic [31:0] TAG_STEP    = 32'h0001_0000,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    base_address_wr_if.master bus
);
    localparam int SW = $clog2(NUM_SLOTS);

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_TAG, WAIT_ACK, DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d, wd_q, wd_d, tag_q, tag_d, timer_q, timer_d, rd_q;
    logic [3:0]    we_q, we_d;
    logic [SW-1:0] slot_q, slot_d;
    logic          en_q, en_d, done_q, done_d, tmo_q, tmo_d, ack, expire;

    // first two WAIT_ACK cycles see stale or pre-write read data, so they never count as an ack
    assign ack    = state_q == WAIT_ACK && timer_q >= 32'd2 && rd_q == ~tag_q;
    assign expire = ACK_TIMEOUT != 0 && timer_q == ACK_TIMEOUT - 1;

    assign bus.ram_clk     = clk;
    assign bus.ram_rst     = 1'b0;
    assign bus.ram_addr    = addr_q;
    assign bus.ram_en      = en_q;
    assign bus.ram_we      = we_q;
    assign bus.ram_wd_data = wd_q;
    assign bus.post_ready  = state_q == IDLE && !rst;
    assign bus.Post_Done   = done_q;
    assign bus.ack_timeout = tmo_q;
    assign bus.slot_idx    = slot_q;

    // next state and the BRAM command for the coming cycle
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wd_d    = wd_q;
        en_d    = 1'b0;
        we_d    = 4'h0;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        tag_d   = tag_q;
        slot_d  = slot_q;
        timer_d = &timer_q ? timer_q : timer_q + 32'd1;
        case (state_q)
            IDLE: if (bus.post_valid) begin
                state_d = WR_DATA;
                addr_d  = START_ADDR + {{(29-SW){1'b0}}, slot_q, 3'b000};
                en_d    = 1'b1;
                we_d    = 4'hF;
                wd_d    = bus.post_data;
            end
            WR_DATA: begin
                state_d = WR_TAG;
                addr_d  = addr_q + 32'd4;
                en_d    = 1'b1;
                we_d    = 4'hF;
                wd_d    = tag_q;
            end
            WR_TAG: begin
                state_d = WAIT_ACK;
                en_d    = 1'b1;
                timer_d = '0;
            end
            WAIT_ACK: if (ack) begin
                state_d = DONE;
                done_d  = 1'b1;
            end else if (expire) begin
                state_d = IDLE;
                tmo_d   = 1'b1;
                tag_d   = tag_q + TAG_STEP;
                slot_d  = slot_q + SW'(1);
            end else begin
                en_d    = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                tag_d   = tag_q + TAG_STEP;
                slot_d  = slot_q + SW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // state, registered BRAM outputs and the read-data capture register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= START_ADDR;
            en_q    <= 1'b0;
            we_q    <= 4'h0;
            wd_q    <= '0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            slot_q  <= '0;
            tag_q   <= TAG_INIT;
            timer_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            en_q    <= en_d;
            we_q    <= we_d;
            wd_q    <= wd_d;
            done_q  <= done_d;
            tmo_q   <= tmo_d;
            slot_q  <= slot_d;
            tag_q   <= tag_d;
            timer_q <= timer_d;
            rd_q    <= bus.ram_rd_data;
        end
    end
endmodule

// File: tb/tb_base_address_wr.sv
// tb_base_address_wr: random posts against a BRAM/PS model and a cycle-level expectation of the mailbox writer
module tb_base_address_wr;
    localparam logic [31:0] START = 32'h4580_0000;
    localparam logic [31:0] INIT  = 32'h0001_0030;
    localparam logic [31:0] STEP  = 32'h0001_0000;
    localparam int          TMO   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    base_address_wr_if #(.SW(4)) bus();
    base_address_wr #(.ACK_TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int n_done = 0, n_tmo = 0, last_evt = 0;
    logic [31:0] mem [32];
    logic [31:0] w_addr [$];
    logic [31:0] w_data [$];
    bit ps_en = 1'b1, pre = 1'b0, pend = 1'b0, started = 1'b0;
    int ack_dly = 0, pcnt = 0, pidx = 0, bk;
    logic [31:0] pval;

    int          m_n = 0;
    bit          m_fin = 1'b0, m_ack;
    logic [3:0]  m_slot = '0;
    logic [31:0] m_tag = INIT, m_rdq = '0, e_addr = START, e_wd = '0;
    logic        e_en = 1'b0, e_done = 1'b0, e_tmo = 1'b0;
    logic [3:0]  e_we = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        logic [31:0] o;
        o = a - START;
        return (o < 32'd128) ? int'(o >> 2) : -1;
    endfunction

    // read-first BRAM, PS acknowledger and write log
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pend) begin
            if (pcnt == 0) begin
                mem[pidx] <= pval;
                pend <= 1'b0;
            end else pcnt <= pcnt - 1;
        end
        if (bus.ram_en) begin
            bk = widx(bus.ram_addr);
            chk("addr_in_ring", 32'(bk >= 0), 32'd1);
            if (bk >= 0) begin
                bus.ram_rd_data <= mem[bk];
                if (bus.ram_we == 4'hF) begin
                    mem[bk] <= bus.ram_wd_data;
                    w_addr.push_back(bus.ram_addr);
                    w_data.push_back(bus.ram_wd_data);
                    if ((bk % 2) == 1 && ps_en) begin
                        pend <= 1'b1;
                        pcnt <= ack_dly;
                        pidx <= bk;
                        pval <= ~bus.ram_wd_data;
                    end
                end
            end
        end
        if (pre) begin
            mem[1] <= 32'hFFFE_FFCF;
            bus.ram_rd_data <= 32'hFFFE_FFCF;
        end
    end

    // compare against the expectation for the last edge, then predict the next edge
    always @(negedge clk) begin
        if (started) begin
            chk("ram_addr", bus.ram_addr, e_addr);
            chk("ram_en", 32'(bus.ram_en), 32'(e_en));
            chk("ram_we", 32'(bus.ram_we), 32'(e_we));
            chk("ram_wd_data", bus.ram_wd_data, e_wd);
            chk("Post_Done", 32'(bus.Post_Done), 32'(e_done));
            chk("ack_timeout", 32'(bus.ack_timeout), 32'(e_tmo));
            chk("post_ready", 32'(bus.post_ready), 32'(m_n == 0 && !m_fin && !rst));
            chk("slot_idx", 32'(bus.slot_idx), 32'(m_slot));
            chk("ram_rst", 32'(bus.ram_rst), 32'd0);
            if (bus.Post_Done) begin n_done++; last_evt = cyc; end
            if (bus.ack_timeout) begin n_tmo++; last_evt = cyc; end
        end
        if (rst) begin
            m_n = 0; m_fin = 1'b0; m_slot = '0; m_tag = INIT; m_rdq = '0;
            e_addr = START; e_en = 1'b0; e_we = '0; e_wd = '0; e_done = 1'b0; e_tmo = 1'b0;
        end else begin
            m_ack = m_n >= 5 && m_rdq == ~m_tag;
            e_done = 1'b0; e_tmo = 1'b0; e_en = 1'b0; e_we = '0;
            if (m_fin) begin
                m_fin = 1'b0; m_tag = m_tag + STEP; m_slot = m_slot + 4'd1;
            end else if (m_n == 0) begin
                if (bus.post_valid) begin
                    m_n = 1; e_addr = START + 32'(m_slot) * 8; e_en = 1'b1; e_we = 4'hF; e_wd = bus.post_data;
                end
            end else if (m_n == 1) begin
                m_n = 2; e_addr = e_addr + 4; e_en = 1'b1; e_we = 4'hF; e_wd = m_tag;
            end else if (m_ack) begin
                m_n = 0; m_fin = 1'b1; e_done = 1'b1;
            end else if (m_n - 2 == TMO) begin
                m_n = 0; e_tmo = 1'b1; m_tag = m_tag + STEP; m_slot = m_slot + 4'd1;
            end else begin
                m_n++; e_en = 1'b1;
            end
            m_rdq = bus.ram_rd_data;
        end
        started = 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_post(input logic [31:0] d, output int t);
        bus.post_valid = 1'b1;
        bus.post_data = d;
        t = -1;
        for (int i = 0; i < 300 && t < 0; i++) begin
            @(negedge clk);
            if (bus.post_ready && !rst) begin
                @(posedge clk);
                #1;
                t = cyc;
            end
        end
        bus.post_valid = 1'b0;
        if (t < 0) chk("post_accepted", 32'd0, 32'd1);
    endtask

    task automatic wait_evt(input int t, output int lat);
        int s;
        s = n_done + n_tmo;
        lat = -1;
        for (int i = 0; i < 300 && lat < 0; i++) begin
            @(negedge clk);
            #1;
            if (n_done + n_tmo != s) lat = last_evt - t;
        end
        if (lat < 0) chk("event_seen", 32'd0, 32'd1);
    endtask

    task automatic pw(input logic [31:0] d, output int lat, output int b);
        int t;
        b = w_addr.size();
        do_post(d, t);
        wait_evt(t, lat);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, b, t, d0, t0;
        bus.post_valid = 1'b0;
        bus.post_data = '0;
        repeat (3) tick();
        chk("rst_addr", bus.ram_addr, START);
        chk("rst_en", 32'(bus.ram_en), 32'd0);
        chk("rst_ready", 32'(bus.post_ready), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_ready", 32'(bus.post_ready), 32'd1);

        pw(32'h1234_5678, lat, b);
        chk("t1_lat", lat, 32'd6);
        chk("t1_done_cnt", n_done, 32'd1);
        chk("t1_data_addr", w_addr[b], 32'h4580_0000);
        chk("t1_data", w_data[b], 32'h1234_5678);
        chk("t1_tag_addr", w_addr[b+1], 32'h4580_0004);
        chk("t1_tag", w_data[b+1], 32'h0001_0030);
        pw($urandom, lat, b);
        chk("t1_tag2_addr", w_addr[b+1], 32'h4580_000C);
        chk("t1_tag2", w_data[b+1], 32'h0002_0030);

        for (int i = 3; i <= 17; i++) begin
            ack_dly = $urandom_range(0, 5);
            d0 = ack_dly;
            pw($urandom, lat, b);
            chk("t2_lat", lat, 32'(6 + d0));
            chk("t2_slot", 32'(bus.slot_idx), 32'(i % 16));
            if (i == 17) begin
                chk("t2_wrap_addr", w_addr[b], 32'h4580_0000);
                chk("t2_wrap_tag", w_data[b+1], 32'h0011_0030);
            end
        end

        ps_en = 1'b0;
        pw($urandom, lat, b);
        chk("t3_lat", lat, 32'd66);
        chk("t3_tmo_cnt", n_tmo, 32'd1);
        chk("t3_done_cnt", n_done, 32'd17);
        chk("t3_ready", 32'(bus.post_ready), 32'd1);
        ps_en = 1'b1;
        ack_dly = 0;
        pw($urandom, lat, b);
        chk("t3_next_tag", w_data[b+1], 32'h0013_0030);

        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        pre = 1'b1;
        tick();
        pre = 1'b0;
        ack_dly = 15;
        pw(32'hCAFE_0004, lat, b);
        chk("t4_lat", lat, 32'd21);
        chk("t4_tag", w_data[b+1], 32'h0001_0030);

        ps_en = 1'b0;
        do_post(32'hDEAD_0005, t);
        while (cyc < t + 4) tick();
        rst = 1'b1;
        tick();
        chk("t5_en", 32'(bus.ram_en), 32'd0);
        chk("t5_we", 32'(bus.ram_we), 32'd0);
        chk("t5_addr", bus.ram_addr, 32'h4580_0000);
        rst = 1'b0;
        ps_en = 1'b1;
        ack_dly = 0;
        pw(32'hBEEF_0005, lat, b);
        chk("t5_lat", lat, 32'd6);
        chk("t5_data_addr", w_addr[b], 32'h4580_0000);
        chk("t5_tag", w_data[b+1], 32'h0001_0030);

        b = w_addr.size();
        t0 = n_done;
        bus.post_data = $urandom;
        bus.post_valid = 1'b1;
        repeat (20) tick();
        bus.post_valid = 1'b0;
        repeat (12) tick();
        chk("t6_writes", 32'(w_addr.size() - b), 32'd6);
        chk("t6_done_cnt", 32'(n_done - t0), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("t6_data_addr", w_addr[b+2*k], START + 32'(8 * (k + 1)));
            chk("t6_tag", w_data[b+2*k+1], INIT + STEP * 32'(k + 1));
        end

        for (int i = 0; i < 40; i++) begin
            ps_en = ($urandom % 8) != 0;
            ack_dly = $urandom_range(0, 11);
            d0 = ps_en ? 6 + ack_dly : 66;
            t0 = n_tmo;
            repeat ($urandom_range(0, 3)) tick();
            pw($urandom, lat, b);
            chk("rnd_lat", lat, 32'(d0));
            chk("rnd_kind", 32'(n_tmo - t0), 32'(ps_en ? 0 : 1));
        end

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
